// File: rtl/periph_bus_pkg.sv
// Peripheral bus master shared types.
// Access sizes, FSM states and request checks.
package periph_bus_pkg;

  localparam int WIN_BITS_DEF = 22;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  function automatic logic bad_align(
    input size_e      sz,
    input logic [1:0] lo
  );
    return (sz == SZ_X)
        || (sz == SZ_H && lo[0])
        || (sz == SZ_W && lo != 2'b00);
  endfunction

endpackage

// File: rtl/periph_lane_align.sv
// Byte/half lane extract for loads and merge for stores.
// Purely combinational; lane chosen by the low address bits.
module periph_lane_align
  import periph_bus_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [1:0]  lo,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // pick the addressed lane, extend it, and splice store data in
  always_comb begin
    byte_v = rdata[{lo, 3'b000} +: 8];
    half_v = rdata[{lo[1], 4'b0000} +: 16];
    ldata  = rdata;
    mdata  = rdata;
    unique case (1'b1)
      size == SZ_B: begin
        ldata = {{24{~uns & byte_v[7]}}, byte_v};
        mdata[{lo, 3'b000} +: 8] = wdata[7:0];
      end
      size == SZ_H: begin
        ldata = {{16{~uns & half_v[15]}}, half_v};
        mdata[{lo[1], 4'b0000} +: 16] = wdata;
      end
      default: begin
        ldata = rdata;
        mdata = rdata;
      end
    endcase
  end

endmodule

// File: rtl/periph_bus_master.sv
// Core load/store to peripheral word bus initiator.
// Sub-word stores are done as read-modify-write.
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int WIN_BITS = WIN_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_uns,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] bus_addr,
  output logic        bus_wr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  state_e      state;
  size_e       size_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  lo_q;
  logic [15:0] wdata_q;
  logic [31:0] ldata;
  logic [31:0] mdata;
  logic        out_win;
  logic        bad;

  assign out_win = (req_addr >> (WIN_BITS + 2)) != 32'd0;
  assign bad = out_win
            || bad_align(size_e'(req_size), req_addr[1:0]);

  periph_lane_align u_align (
    .size  (size_q),
    .uns   (uns_q),
    .lo    (lo_q),
    .rdata (bus_rdata),
    .wdata (wdata_q),
    .ldata (ldata),
    .mdata (mdata)
  );

  // request FSM with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      bus_addr   <= '0;
      bus_wr     <= 1'b0;
      bus_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      bus_wr     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          bus_addr  <= '0;
          bus_wdata <= '0;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            size_q    <= size_e'(req_size);
            uns_q     <= req_uns;
            lo_q      <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            if (bad) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we && req_size == SZ_W) begin
              state     <= ST_WRITE;
              bus_addr  <= {2'b00, req_addr[31:2]};
              bus_wr    <= 1'b1;
              bus_wdata <= req_wdata;
            end else begin
              state    <= ST_READ;
              bus_addr <= {2'b00, req_addr[31:2]};
            end
          end
        end
        ST_READ: begin
          if (we_q) begin
            state     <= ST_WRITE;
            bus_wr    <= 1'b1;
            bus_wdata <= mdata;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= ldata;
            bus_addr   <= '0;
          end
        end
        ST_WRITE: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          bus_addr   <= '0;
          bus_wdata  <= '0;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master: transaction-level model,
// per-cycle output compare, directed and random requests.
module tb_periph_bus_master;

  localparam int WIN_BITS = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] bus_addr;
  logic        bus_wr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  periph_bus_master #(.WIN_BITS(WIN_BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_uns    (req_uns),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .bus_addr   (bus_addr),
    .bus_wr     (bus_wr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata)
  );

  logic [31:0] regs [16] = '{default: 32'd0};
  assign bus_rdata = regs[bus_addr[3:0]];
  always @(posedge clk) if (bus_wr) regs[bus_addr[3:0]] <= bus_wdata;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic        err;
    logic        wr;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cyc_t;

  cyc_t        q[$];
  cyc_t        cur;
  logic [31:0] mem [16] = '{default: 32'd0};
  bit          armed = 0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int lat = 0;
  int resp_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: schedule the expected per-cycle outputs of each request
  always @(posedge clk) begin : model
    cyc_t        e;
    logic [31:0] a, old, v, mask, mrg;
    int          sh, wd;
    bit          bad;
    cyc++;
    if (!rst) begin
      q.delete();
      cur = '0;
      armed = 1;
    end else if (armed) begin
      if (q.size() == 0 && cur.ready && req_valid) begin
        acc_cyc = cyc;
        a = req_addr;
        bad = (req_size == 3)
           || (req_size == 1 && a % 2 != 0)
           || (req_size == 2 && a % 4 != 0)
           || (64'(a) >= (64'd1 << (WIN_BITS + 2)));
        old = mem[a[5:2]];
        e = '0;
        e.addr = a / 4;
        if (bad) begin
          e = '0; e.valid = 1; e.err = 1;
          q.push_back(e);
        end else if (req_we && req_size == 2) begin
          e.wr = 1; e.wdata = req_wdata;
          q.push_back(e);
          e = '0; e.valid = 1;
          q.push_back(e);
        end else begin
          q.push_back(e);
          wd = (req_size == 0) ? 8 : 16;
          sh = (req_size == 0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
          if (req_size == 2) begin
            v = old;
          end else begin
            v = (old >> sh) & ((32'd1 << wd) - 1);
            if (!req_uns && v >= (32'd1 << (wd - 1)))
              v = v | ~((32'd1 << wd) - 1);
          end
          if (req_we) begin
            mask = ((32'd1 << wd) - 1) << sh;
            mrg = (old & ~mask) | ((req_wdata << sh) & mask);
            e.wr = 1; e.wdata = mrg;
            q.push_back(e);
            e = '0; e.valid = 1;
          end else begin
            e = '0; e.valid = 1; e.rdata = v;
          end
          q.push_back(e);
        end
      end
      if (q.size() != 0) cur = q.pop_front();
      else begin cur = '0; cur.ready = 1; end
      if (cur.wr) mem[cur.addr[3:0]] = cur.wdata;
    end
    #1;
    if (armed) begin
      chk("cycle",
          {28'd0, req_ready, resp_valid, resp_err, bus_wr,
           resp_rdata, bus_addr, bus_wdata},
          {28'd0, cur});
      if (resp_valid) begin
        resp_cnt++;
        last_rdata = resp_rdata;
        last_err = resp_err;
        lat = cyc - acc_cyc + 1;
      end
      if (bus_wr) begin
        wr_cnt++;
        last_wr_addr = bus_addr;
        last_wr_data = bus_wdata;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_uns = uns;
    req_addr = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 128'(n), 128'd0);
    else @(posedge clk);
  endtask

  task automatic wait_resp(input int n0);
    int n;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (resp_cnt == n0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("resp_seen", 128'(resp_cnt != n0), 128'd1);
  endtask

  task automatic txn(input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr,
                     input logic [31:0] wd);
    int n0;
    n0 = resp_cnt;
    issue(we, sz, uns, addr, wd);
    wait_resp(n0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int w0, r0, k;
    logic [31:0] ad;
    logic [1:0]  sz;
    logic [1:0]  esz [4];
    logic [31:0] ead [4];
    esz = '{2'd2, 2'd1, 2'd3, 2'd2};
    ead = '{32'h6, 32'h1, 32'h0, 32'h0100_0000};

    repeat (3) @(negedge clk);
    chk("reset_ready", 128'(req_ready), 128'd0);
    chk("reset_resp", 128'(resp_valid), 128'd0);
    chk("reset_bus_wr", 128'(bus_wr), 128'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    txn(1, 2, 0, 32'h4, 32'hDEAD_BEEF);
    chk("wstore_lat", 128'(lat), 128'd2);
    chk("wstore_err", 128'(last_err), 128'd0);
    chk("wstore_addr", 128'(last_wr_addr), 128'd1);
    chk("wstore_data", 128'(last_wr_data), 128'hDEAD_BEEF);

    txn(1, 2, 0, 32'h0, 32'h1122_3344);
    w0 = wr_cnt;
    txn(1, 0, 0, 32'h2, 32'h0000_00AB);
    chk("bstore_data", 128'(last_wr_data), 128'h11AB_3344);
    chk("bstore_lat", 128'(lat), 128'd3);
    chk("bstore_wrs", 128'(wr_cnt - w0), 128'd1);

    txn(1, 2, 0, 32'h0, 32'h80FF_0000);
    txn(0, 1, 0, 32'h2, 32'h0);
    chk("lh_signed", 128'(last_rdata), 128'hFFFF_80FF);
    chk("load_lat", 128'(lat), 128'd2);
    txn(0, 1, 1, 32'h2, 32'h0);
    chk("lh_unsigned", 128'(last_rdata), 128'h0000_80FF);
    txn(0, 0, 0, 32'h2, 32'h0);
    chk("lb_signed", 128'(last_rdata), 128'hFFFF_FFFF);

    for (int i = 0; i < 4; i++) begin
      w0 = wr_cnt;
      txn(i[0], esz[i], 0, ead[i], 32'h1234_5678);
      chk("err_flag", 128'(last_err), 128'd1);
      chk("err_lat", 128'(lat), 128'd1);
      chk("err_rdata", 128'(last_rdata), 128'd0);
      chk("err_no_wr", 128'(wr_cnt - w0), 128'd0);
    end

    r0 = resp_cnt;
    issue(0, 2, 0, 32'h4, 32'h0);
    issue(0, 2, 0, 32'h0, 32'h0);
    wait_resp(r0 + 1);
    chk("b2b_count", 128'(resp_cnt - r0), 128'd2);
    chk("b2b_data", 128'(last_rdata), 128'h80FF_0000);

    w0 = wr_cnt;
    r0 = resp_cnt;
    issue(1, 0, 0, 32'h1, 32'h55);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_wr", 128'(wr_cnt - w0), 128'd0);
    chk("abort_no_resp", 128'(resp_cnt - r0), 128'd0);
    txn(0, 2, 0, 32'h0, 32'h0);
    chk("abort_reg0", 128'(last_rdata), 128'h80FF_0000);

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0)
        ad = $urandom_range(0, 63) | (32'd1 << $urandom_range(24, 31));
      else if (k == 1)
        ad = $urandom & 32'h00FF_FFFF;
      else
        ad = $urandom_range(0, 63);
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), ad, $urandom);
      k = $urandom_range(0, 29);
      if (k == 0) begin
        @(negedge clk);
        req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else if (k >= 10) begin
        @(negedge clk);
        req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
